// File: rtl/instr_fetch_unit.sv
// Fetch front end: one outstanding req/gnt/rvalid word read feeding a 2-entry {pc, instr} queue to decode.
// Latency rvalid->out_valid 1 cycle; no request while queue full; FETCH_MISALIGN_TRAP_EN enables misaligned-redirect halt.
module instr_fetch_unit #(
   parameter int             n        = 32,
   parameter logic [n-1:0]   RESET_PC = '0,
   parameter int             DEPTH    = 2
) (
   input  logic         clk,
   input  logic         rst,
   output logic         mem_req,
   output logic [n-1:0] mem_addr,
   input  logic         mem_gnt,
   input  logic         mem_rvalid,
   input  logic [n-1:0] mem_rdata,
   input  logic         redirect_valid,
   input  logic [n-1:0] redirect_pc,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [n-1:0] out_instr,
   output logic [n-1:0] out_pc,
   output logic         fetch_misalign
);

   typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

   localparam logic [1:0] DEPTH_C = 2'(DEPTH);

   state_t       state;
   logic [n-1:0] fetch_pc;
   logic [1:0]   count;
   logic [n-1:0] q_pc    [2];
   logic [n-1:0] q_instr [2];
   logic [n-1:0] tgt_pc;
   logic         halted;
   logic         push, pop, wr_hi;

`ifdef FETCH_MISALIGN_TRAP_EN
   assign tgt_pc = redirect_pc;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         halted <= 1'b0;
      else if (redirect_valid)
         halted <= (redirect_pc[1:0] != 2'b00);
   end
`else
   assign tgt_pc = redirect_pc & ~n'(3);
   assign halted = 1'b0;
`endif

   assign fetch_misalign = halted;

   // rst gating keeps mem_req low for the whole reset window, not just after the first edge
   assign mem_req   = rst && (state == IDLE) && (count < DEPTH_C) && !halted;
   assign mem_addr  = fetch_pc;
   assign out_valid = (count != 2'd0);
   assign out_pc    = q_pc[0];
   assign out_instr = q_instr[0];

   assign push  = (state == WAIT) && mem_rvalid && !redirect_valid;
   assign pop   = out_valid && out_ready && !redirect_valid;
   // slot for the incoming word, after any same-cycle pop has shifted the queue down
   assign wr_hi = pop ? (count == 2'd2) : (count == 2'd1);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         fetch_pc   <= RESET_PC;
         count      <= 2'd0;
         q_pc[0]    <= '0;
         q_pc[1]    <= '0;
         q_instr[0] <= '0;
         q_instr[1] <= '0;
      end else begin
         case (state)
            IDLE:  if (mem_req && mem_gnt) state <= redirect_valid ? DRAIN : WAIT;
            WAIT:  if (redirect_valid)     state <= mem_rvalid ? IDLE : DRAIN;
                   else if (mem_rvalid)    state <= IDLE;
            DRAIN: if (mem_rvalid)         state <= IDLE;
            default:                       state <= IDLE;
         endcase

         if (redirect_valid)
            fetch_pc <= tgt_pc;
         else if (push)
            fetch_pc <= fetch_pc + n'(4);

         if (redirect_valid) begin
            count <= 2'd0;
         end else begin
            if (pop) begin
               q_pc[0]    <= q_pc[1];
               q_instr[0] <= q_instr[1];
            end
            if (push) begin
               if (wr_hi) begin
                  q_pc[1]    <= fetch_pc;
                  q_instr[1] <= mem_rdata;
               end else begin
                  q_pc[0]    <= fetch_pc;
                  q_instr[0] <= mem_rdata;
               end
            end
            count <= count + 2'(push) - 2'(pop);
         end
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: random memory/decode/redirect traffic checked every cycle against a queue model.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_gnt = 1'b0;
   logic        mem_rvalid = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic        fetch_misalign;

   instr_fetch_unit dut (
      .clk(clk), .rst(rst),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_instr(out_instr), .out_pc(out_pc),
      .fetch_misalign(fetch_misalign)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] memf(input logic [31:0] a);
      return a ^ 32'h0000_0013;
   endfunction

   function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
      if (i < q.size()) return q[i];
      return 32'hBAD0_BAD0;
   endfunction

   // stimulus knobs (written by the main sequence only)
   bit          rst_req = 1'b1;
   int          rdy_pct = 100, gnt_pct = 100, lat_min = 1, lat_max = 1, redir_pct = 0;
   int          redir_mode = 0;
   logic [31:0] redir_tgt = '0;
   int          arm_req = 0;
   int          arm_ack = 0;

   // model: expected decode queue, memory's outstanding read, expected fetch address
   typedef struct packed { logic [31:0] pc; logic [31:0] instr; } ent_t;
   ent_t        mq[$];
   bit          mo = 1'b0, mo_stale = 1'b0;
   logic [31:0] mo_addr = '0;
   int          mo_lat = 0;
   logic [31:0] exp_fetch = '0;
   bit          m_halt = 1'b0;
   int          cyc = 0;
   logic [31:0] pop_pc[$], pop_instr[$], gnt_addr[$];
   int          pop_cyc[$];

   task automatic clear_logs();
      pop_pc.delete(); pop_instr.delete(); gnt_addr.delete(); pop_cyc.delete();
   endtask

   initial begin : drv
      logic [31:0] tgt;
      bit          fire, redir, exp_req;
      rst = 1'b1;
      #2 rst = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst) begin
            chk("rst_mem_req", mem_req, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_pc", out_pc, 0);
            chk("rst_out_instr", out_instr, 0);
            chk("rst_misalign", fetch_misalign, 0);
         end else begin
            exp_req = !mo && (mq.size() < 2) && !m_halt;
            chk("mem_req", mem_req, exp_req);
            chk("out_valid", out_valid, mq.size() != 0);
            if (mq.size() != 0) begin
               chk("out_pc", out_pc, mq[0].pc);
               chk("out_instr", out_instr, mq[0].instr);
            end
            chk("fetch_misalign", fetch_misalign, m_halt);
         end

         rst        = !rst_req;
         out_ready  = ($urandom_range(0, 99) < rdy_pct);
         mem_rvalid = 1'b0;
         mem_rdata  = $urandom;
         if (mo && rst) begin
            mo_lat--;
            if (mo_lat == 0) begin
               mem_rvalid = 1'b1;
               mem_rdata  = memf(mo_addr);
            end
         end
         #1;
         mem_gnt = rst && mem_req && !mo && ($urandom_range(0, 99) < gnt_pct);
         redirect_valid = 1'b0;
         redirect_pc    = $urandom;
         fire = 1'b0;
         if (rst && arm_req != arm_ack) begin
            case (redir_mode)
               1:       fire = mo && !mem_rvalid && !mo_stale;
               2:       fire = mem_gnt;
               default: fire = 1'b1;
            endcase
         end
         if (fire) begin
            redirect_valid = 1'b1;
            redirect_pc    = redir_tgt;
            arm_ack        = arm_req;
         end else if (rst && $urandom_range(0, 99) < redir_pct) begin
            tgt = $urandom;
            case ($urandom_range(0, 3))
               0:       ;
               1:       tgt = {28'hFFFF_FFF, tgt[3:2], 2'b00};
               default: tgt = {tgt[31:2], 2'b00};
            endcase
            redirect_valid = 1'b1;
            redirect_pc    = tgt;
         end

         if (!rst) begin
            mq.delete();
            mo = 1'b0; mo_stale = 1'b0;
            exp_fetch = 32'h0;
            m_halt = 1'b0;
         end else begin
            redir = redirect_valid;
            if (mq.size() != 0 && out_ready && !redir) begin
               pop_pc.push_back(mq[0].pc);
               pop_instr.push_back(mq[0].instr);
               pop_cyc.push_back(cyc);
               void'(mq.pop_front());
            end
            if (mem_rvalid) begin
               mo = 1'b0;
               if (!mo_stale && !redir) begin
                  mq.push_back({mo_addr, memf(mo_addr)});
                  exp_fetch = exp_fetch + 32'd4;
               end
            end
            if (mem_gnt) begin
               chk("gnt_addr", mem_addr, exp_fetch);
               gnt_addr.push_back(mem_addr);
               mo = 1'b1; mo_addr = mem_addr; mo_stale = 1'b0;
               mo_lat = $urandom_range(lat_min, lat_max);
            end
            if (redir) begin
               mq.delete();
               if (mo) mo_stale = 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
               exp_fetch = redirect_pc;
               m_halt    = (redirect_pc[1:0] != 2'b00);
`else
               exp_fetch = redirect_pc & ~32'd3;
`endif
            end
            if (fire) clear_logs();
         end
      end
   end

   task automatic wait_cyc(input int k);
      repeat (k) @(posedge clk);
      #1;
   endtask

   task automatic arm(input int mode, input logic [31:0] t);
      redir_mode = mode;
      redir_tgt  = t;
      arm_req++;
   endtask

   initial begin
      // reset and straight-line fetch with 1-cycle memory
      wait_cyc(4);
      chk("lit_rst_req", mem_req, 0);
      chk("lit_rst_valid", out_valid, 0);
      clear_logs();
      rst_req = 1'b0;
      wait_cyc(14);
      chk("p1_pc0", qget(pop_pc, 0), 32'h0);
      chk("p1_pc1", qget(pop_pc, 1), 32'h4);
      chk("p1_pc2", qget(pop_pc, 2), 32'h8);
      chk("p1_instr0", qget(pop_instr, 0), 32'h0000_0013);
      chk("p1_npop", pop_cyc.size() >= 3, 1);
      if (pop_cyc.size() >= 3) begin
         chk("p1_gap01", pop_cyc[1] - pop_cyc[0], 2);
         chk("p1_gap12", pop_cyc[2] - pop_cyc[1], 2);
      end

      // mid-run reset, then decode stalled: queue fills and fetch stops
      rst_req = 1'b1;
      wait_cyc(3);
      rdy_pct = 0;
      rst_req = 1'b0;
      wait_cyc(10);
      chk("p2_full_valid", out_valid, 1);
      chk("p2_full_req", mem_req, 0);
      chk("p2_head_pc", out_pc, 32'h0);
      clear_logs();
      rdy_pct = 100;
      wait_cyc(10);
      chk("p2_pc0", qget(pop_pc, 0), 32'h0);
      chk("p2_pc1", qget(pop_pc, 1), 32'h4);
      chk("p2_resume", qget(gnt_addr, 0), 32'h8);

      // redirect while a 3-cycle read is in flight
      lat_min = 3; lat_max = 3;
      arm(1, 32'h100);
      wait_cyc(25);
      chk("p3_fired", arm_ack == arm_req, 1);
      chk("p3_gnt", qget(gnt_addr, 0), 32'h100);
      chk("p3_pc", qget(pop_pc, 0), 32'h100);

      // redirect coinciding with grant
      lat_min = 1; lat_max = 2;
      arm(2, 32'h200);
      wait_cyc(20);
      chk("p4_fired", arm_ack == arm_req, 1);
      chk("p4_gnt", qget(gnt_addr, 0), 32'h200);
      chk("p4_pc", qget(pop_pc, 0), 32'h200);
      chk("p4_instr", qget(pop_instr, 0), 32'h213);

      // address wrap
      lat_min = 2; lat_max = 2;
      arm(1, 32'hFFFF_FFFC);
      wait_cyc(20);
      chk("p5_fired", arm_ack == arm_req, 1);
      chk("p5_pc0", qget(pop_pc, 0), 32'hFFFF_FFFC);
      chk("p5_pc1", qget(pop_pc, 1), 32'h0);

      // misaligned redirect
      lat_min = 1; lat_max = 1;
      arm(3, 32'h102);
      wait_cyc(10);
`ifdef FETCH_MISALIGN_TRAP_EN
      chk("p6_trap", fetch_misalign, 1);
      chk("p6_no_req", gnt_addr.size(), 0);
      arm(3, 32'h200);
      wait_cyc(10);
      chk("p6_clear", fetch_misalign, 0);
      chk("p6_gnt", qget(gnt_addr, 0), 32'h200);
`else
      chk("p6_gnt", qget(gnt_addr, 0), 32'h100);
      chk("p6_pc", qget(pop_pc, 0), 32'h100);
`endif

      // randomized traffic with a reset pulse in the middle
      redir_pct = 5;
      lat_min = 1; lat_max = 4;
      clear_logs();
      for (int i = 0; i < 3000; i++) begin
         if (i % 500 == 0) begin
            rdy_pct = $urandom_range(20, 100);
            gnt_pct = $urandom_range(30, 100);
         end
         if (i == 1500) rst_req = 1'b1;
         if (i == 1503) rst_req = 1'b0;
         @(posedge clk);
      end
      redir_pct = 0;
      rdy_pct = 100;
      gnt_pct = 100;
      arm(3, 32'h40);
      wait_cyc(30);
      chk("rand_progress", pop_pc.size() > 0, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
